// File: rtl/tawas_imem.sv
// tawas_imem: single-port instruction memory shared by a never-stalling
// fetch port and a lower-priority handshaked loader port.
// Optional feature: define TAWAS_IMEM_PARITY_EN to store and check an
// even-parity bit per word.
module tawas_imem #(
    parameter int unsigned ADDR_W    = 12,
    parameter logic [31:0] HALT_WORD = 32'hC0000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ics,
    input  logic [23:0] iaddr,
    output logic [31:0] idata,
    input  logic        ld_req,
    input  logic        ld_we,
    input  logic [23:0] ld_addr,
    input  logic [31:0] ld_wdata,
    output logic        ld_ack,
    output logic [31:0] ld_rdata,
    output logic        par_err
);

`ifdef TAWAS_IMEM_PARITY_EN
    localparam int unsigned MEM_W = 33;
`else
    localparam int unsigned MEM_W = 32;
`endif

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    logic [MEM_W-1:0] mem [0:(1 << ADDR_W) - 1];

    state_t           state_q, state_d;
    logic [31:0]      idata_q, idata_d;
    logic [31:0]      ld_rdata_q, ld_rdata_d;
    logic             par_err_d;
    logic             fetch_in_range;
    logic             ld_in_range;
    logic [MEM_W-1:0] fetch_word;
    logic             access;
    logic             mem_we;
    logic [MEM_W-1:0] mem_wdata;

    // Fetch path: out-of-range and parity-faulted fetches yield the halt word
    always_comb begin
        fetch_in_range = (iaddr >> ADDR_W) == 24'd0;
        fetch_word     = '0;
        idata_d        = idata_q;
        par_err_d      = 1'b0;
        if (ics) begin
            if (fetch_in_range) begin
                fetch_word = mem[iaddr[ADDR_W-1:0]];
`ifdef TAWAS_IMEM_PARITY_EN
                if ((^fetch_word[31:0]) != fetch_word[32]) begin
                    idata_d   = HALT_WORD;
                    par_err_d = 1'b1;
                end else begin
                    idata_d = fetch_word[31:0];
                end
`else
                idata_d = fetch_word;
`endif
            end else begin
                idata_d = HALT_WORD;
            end
        end
    end

    // Loader FSM: an access only happens in a cycle with ics low
    always_comb begin
        ld_in_range = (ld_addr >> ADDR_W) == 24'd0;
        state_d     = state_q;
        access      = 1'b0;
        case (state_q)
            IDLE: begin
                if (ld_req) begin
                    if (ics) begin
                        state_d = WAIT;
                    end else begin
                        access  = 1'b1;
                        state_d = ACK;
                    end
                end
            end
            WAIT: begin
                if (!ics) begin
                    access  = 1'b1;
                    state_d = ACK;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Reset holds the FSM in IDLE, so gate the access explicitly to keep
        // a still-asserted request from writing while rst_n is low.
        mem_we    = access && rst_n && ld_we && ld_in_range;
`ifdef TAWAS_IMEM_PARITY_EN
        mem_wdata = {^ld_wdata, ld_wdata};
`else
        mem_wdata = ld_wdata;
`endif
        ld_rdata_d = ld_rdata_q;
        if (access) begin
            if (!ld_we && ld_in_range) begin
                ld_rdata_d = mem[ld_addr[ADDR_W-1:0]][31:0];
            end else begin
                ld_rdata_d = '0;
            end
        end
    end

    // Storage array, never reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[ld_addr[ADDR_W-1:0]] <= mem_wdata;
        end
    end

    // Control and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idata_q    <= '0;
            ld_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            idata_q    <= idata_d;
            ld_rdata_q <= ld_rdata_d;
        end
    end

`ifdef TAWAS_IMEM_PARITY_EN
    logic par_err_q;

    // Parity error pulse aligned with the returned halt word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end

    assign par_err = par_err_q;
`else
    assign par_err = 1'b0;
`endif

    assign idata    = idata_q;
    assign ld_ack   = (state_q == ACK);
    assign ld_rdata = ld_ack ? ld_rdata_q : '0;

endmodule

// File: tb/tb_tawas_imem.sv
// Directed self-checking bench for tawas_imem.
// Inputs are driven and outputs checked 1 time unit after each rising edge.
module tb_tawas_imem;

    logic        clk;
    logic        rst_n;
    logic        ics;
    logic [23:0] iaddr;
    logic [31:0] idata;
    logic        ld_req;
    logic        ld_we;
    logic [23:0] ld_addr;
    logic [31:0] ld_wdata;
    logic        ld_ack;
    logic [31:0] ld_rdata;
    logic        par_err;

    int checks = 0;
    int errors = 0;

    tawas_imem #(.ADDR_W(12), .HALT_WORD(32'hC0000000)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ics      (ics),
        .iaddr    (iaddr),
        .idata    (idata),
        .ld_req   (ld_req),
        .ld_we    (ld_we),
        .ld_addr  (ld_addr),
        .ld_wdata (ld_wdata),
        .ld_ack   (ld_ack),
        .ld_rdata (ld_rdata),
        .par_err  (par_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Full loader write with ics low; a missing ack within the bound is an error
    task automatic load_write(input logic [23:0] a, input logic [31:0] d);
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = a; ld_wdata = d; ics = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (ld_ack) break;
        end
        checks++;
        if (ld_ack !== 1'b1) begin
            errors++;
            $display("FAIL load_write_ack addr=%h: got %b expected 1", a, ld_ack);
        end
        ld_req = 1'b0; ld_we = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ics = 1'b0; iaddr = '0;
        ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;
        cyc(); cyc();
        checks++; if (idata !== 32'h0) begin errors++; $display("FAIL reset_idata: got %h expected 00000000", idata); end
        checks++; if (ld_ack !== 1'b0) begin errors++; $display("FAIL reset_ld_ack: got %b expected 0", ld_ack); end
        checks++; if (ld_rdata !== 32'h0) begin errors++; $display("FAIL reset_ld_rdata: got %h expected 00000000", ld_rdata); end
        checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL reset_par_err: got %b expected 0", par_err); end
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_load_then_fetch();
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 24'd5; ld_wdata = 32'h12345678; ics = 1'b0;
        cyc();
        checks++; if (ld_ack !== 1'b1) begin errors++; $display("FAIL lf_ack: got %b expected 1", ld_ack); end
        checks++; if (ld_rdata !== 32'h0) begin errors++; $display("FAIL lf_wr_rdata: got %h expected 00000000", ld_rdata); end
        ld_req = 1'b0; ld_we = 1'b0; ics = 1'b1; iaddr = 24'd5;
        cyc();
        checks++; if (ld_ack !== 1'b0) begin errors++; $display("FAIL lf_ack_drop: got %b expected 0", ld_ack); end
        checks++; if (idata !== 32'h12345678) begin errors++; $display("FAIL lf_fetch: got %h expected 12345678", idata); end
        checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL lf_par_err: got %b expected 0", par_err); end
        ics = 1'b0; iaddr = 24'd7;
        cyc();
        checks++; if (idata !== 32'h12345678) begin errors++; $display("FAIL lf_hold: got %h expected 12345678", idata); end
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 24'd5;
        cyc();
        checks++; if (ld_ack !== 1'b1) begin errors++; $display("FAIL lf_rd_ack: got %b expected 1", ld_ack); end
        checks++; if (ld_rdata !== 32'h12345678) begin errors++; $display("FAIL lf_rd_data: got %h expected 12345678", ld_rdata); end
        ld_req = 1'b0;
        cyc();
        checks++; if (ld_rdata !== 32'h0) begin errors++; $display("FAIL lf_rdata_idle: got %h expected 00000000", ld_rdata); end
    endtask

    task automatic test_fetch_priority();
        load_write(24'd9, 32'h11111111);
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 24'd9; ld_wdata = 32'hDEADBEEF;
        ics = 1'b1; iaddr = 24'd9;
        for (int i = 0; i < 10; i++) begin
            cyc();
            checks++; if (ld_ack !== 1'b0) begin errors++; $display("FAIL prio_ack_c%0d: got %b expected 0", i, ld_ack); end
            checks++; if (idata !== 32'h11111111) begin errors++; $display("FAIL prio_old_c%0d: got %h expected 11111111", i, idata); end
        end
        ics = 1'b0;
        cyc();
        checks++; if (ld_ack !== 1'b1) begin errors++; $display("FAIL prio_ack_late: got %b expected 1", ld_ack); end
        ld_req = 1'b0; ld_we = 1'b0; ics = 1'b1; iaddr = 24'd9;
        cyc();
        checks++; if (idata !== 32'hDEADBEEF) begin errors++; $display("FAIL prio_new: got %h expected DEADBEEF", idata); end
        checks++; if (ld_ack !== 1'b0) begin errors++; $display("FAIL prio_ack_once: got %b expected 0", ld_ack); end
        ics = 1'b0;
        cyc();
    endtask

    task automatic test_out_of_range();
        ics = 1'b1; iaddr = 24'h001000;
        cyc();
        checks++; if (idata !== 32'hC0000000) begin errors++; $display("FAIL oor_fetch: got %h expected C0000000", idata); end
        checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL oor_par_err: got %b expected 0", par_err); end
        ics = 1'b0;
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 24'h001000;
        cyc();
        checks++; if (ld_ack !== 1'b1) begin errors++; $display("FAIL oor_rd_ack: got %b expected 1", ld_ack); end
        checks++; if (ld_rdata !== 32'h0) begin errors++; $display("FAIL oor_rd_data: got %h expected 00000000", ld_rdata); end
        ld_req = 1'b0;
        cyc();
        // Out-of-range write must not alias onto address 5
        load_write(24'h001005, 32'hAAAA5555);
        ics = 1'b1; iaddr = 24'd5;
        cyc();
        checks++; if (idata !== 32'h12345678) begin errors++; $display("FAIL oor_wr_discard: got %h expected 12345678", idata); end
        ics = 1'b0;
        cyc();
    endtask

    task automatic test_back_to_back();
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 24'd20; ld_wdata = 32'h0BADF00D; ics = 1'b0;
        cyc();
        checks++; if (ld_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack: got %b expected 1", ld_ack); end
        ld_req = 1'b0; ld_we = 1'b0; ics = 1'b1; iaddr = 24'd20;
        cyc();
        checks++; if (idata !== 32'h0BADF00D) begin errors++; $display("FAIL b2b_fetch: got %h expected 0BADF00D", idata); end
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 24'd20; ld_wdata = 32'hCAFEF00D; ics = 1'b0;
        cyc();
        ld_req = 1'b0; ld_we = 1'b0; ics = 1'b1; iaddr = 24'd20;
        cyc();
        checks++; if (idata !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_refetch: got %h expected CAFEF00D", idata); end
        ics = 1'b0;
        cyc();
    endtask

    task automatic test_reset_in_wait();
        load_write(24'd30, 32'h55AA55AA);
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 24'd30; ld_wdata = 32'hFFFFFFFF;
        ics = 1'b1; iaddr = 24'd30;
        cyc(); cyc(); cyc();
        rst_n = 1'b0;
        #1;
        checks++; if (idata !== 32'h0) begin errors++; $display("FAIL rw_idata: got %h expected 00000000", idata); end
        checks++; if (ld_ack !== 1'b0) begin errors++; $display("FAIL rw_ack: got %b expected 0", ld_ack); end
        checks++; if (ld_rdata !== 32'h0) begin errors++; $display("FAIL rw_rdata: got %h expected 00000000", ld_rdata); end
        checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL rw_par_err: got %b expected 0", par_err); end
        // Request still present with ics low while in reset: must not write
        ics = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cyc();
            checks++; if (ld_ack !== 1'b0) begin errors++; $display("FAIL rw_ack_in_reset_c%0d: got %b expected 0", i, ld_ack); end
        end
        ld_req = 1'b0; ld_we = 1'b0;
        rst_n = 1'b1;
        cyc();
        checks++; if (ld_ack !== 1'b0) begin errors++; $display("FAIL rw_ack_after: got %b expected 0", ld_ack); end
        ics = 1'b1; iaddr = 24'd30;
        cyc();
        checks++; if (idata !== 32'h55AA55AA) begin errors++; $display("FAIL rw_word_kept: got %h expected 55AA55AA", idata); end
        ics = 1'b0;
        cyc();
    endtask

`ifdef TAWAS_IMEM_PARITY_EN
    task automatic test_parity();
        load_write(24'd40, 32'h0F0F0F0F);
        dut.mem[40][32] = ~dut.mem[40][32];
        ics = 1'b1; iaddr = 24'd40;
        cyc();
        checks++; if (idata !== 32'hC0000000) begin errors++; $display("FAIL par_fetch: got %h expected C0000000", idata); end
        checks++; if (par_err !== 1'b1) begin errors++; $display("FAIL par_pulse: got %b expected 1", par_err); end
        ics = 1'b0;
        cyc();
        checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL par_pulse_end: got %b expected 0", par_err); end
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 24'd40;
        cyc();
        checks++; if (ld_rdata !== 32'h0F0F0F0F) begin errors++; $display("FAIL par_raw_read: got %h expected 0F0F0F0F", ld_rdata); end
        ld_req = 1'b0;
        cyc();
    endtask
`endif

    initial begin
        test_reset();
        test_load_then_fetch();
        test_fetch_priority();
        test_out_of_range();
        test_back_to_back();
        test_reset_in_wait();
`ifdef TAWAS_IMEM_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tawas_imem.md
TAWAS_IMEM -- requirements
Module: tawas_imem

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, word-address width of storage (2^ADDR_W 32-bit words).
REQ-002 SHALL have parameter HALT_WORD, default 32'hC0000000, the word returned for out-of-range or faulted fetches; it is the fetch unit's halt encoding.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 ics  input  1  fetch chip-select from the fetch unit, one word per asserted cycle.
REQ-006 iaddr  input  24  fetch word address.
REQ-007 idata  output  32  fetch read data.
REQ-008 ld_req  input  1  loader request, held high until ld_ack.
REQ-009 ld_we  input  1  loader write (1) or read (0); stable while ld_req is high.
REQ-010 ld_addr  input  24  loader word address; stable while ld_req is high.
REQ-011 ld_wdata  input  32  loader write data; stable while ld_req is high.
REQ-012 ld_ack  output  1  one-cycle completion pulse for a loader access.
REQ-013 ld_rdata  output  32  loader read data, valid while ld_ack is high.
REQ-014 par_err  output  1  one-cycle fetch parity-error pulse (see Configuration).

Function
REQ-015 Fetch SHALL never stall; ics at cycle N SHALL present the word at iaddr on idata at cycle N+1.
REQ-016 idata SHALL hold its last value through cycles that follow a cycle with ics low.
REQ-017 A fetch with iaddr[23:ADDR_W] nonzero SHALL return HALT_WORD and SHALL NOT access storage.
REQ-018 The loader SHALL be controlled by a state machine with states IDLE, WAIT and ACK.
REQ-019 IDLE: ld_req high with ics low SHALL perform the access that cycle and go to ACK; ld_req high with ics high SHALL go to WAIT.
REQ-020 WAIT: the access SHALL be performed in the first cycle with ics low, then the machine SHALL go to ACK; while ics stays high it SHALL remain in WAIT indefinitely.
REQ-021 ACK: ld_ack SHALL be high for exactly one cycle, then the machine SHALL return to IDLE; a request still present in IDLE is treated as a new request.
REQ-022 Fetch SHALL have strict priority: storage SHALL never perform a loader access in a cycle with ics high.
REQ-023 A loader write performed at cycle N SHALL be visible to a fetch of the same address issued at cycle N+1 or later.
REQ-024 A loader read SHALL return the stored 32-bit word on ld_rdata with ld_ack; an out-of-range loader read SHALL return 32'h0; an out-of-range loader write SHALL be acknowledged and discarded.
REQ-025 ld_rdata SHALL be 32'h0 whenever ld_ack is low.

Reset
REQ-026 While rst_n is low: idata=32'h0, ld_ack=0, ld_rdata=32'h0, par_err=0, state=IDLE.
REQ-027 Storage contents SHALL NOT be reset.
REQ-028 Reset asserted during WAIT or ACK SHALL drop the pending access without any write; the requester re-presents it after reset.

Configuration
REQ-029 Macro TAWAS_IMEM_PARITY_EN SHALL compile in a parity bit per word.
REQ-030 With the macro defined: even parity of the write data SHALL be stored on loader writes; a fetch whose stored parity mismatches SHALL return HALT_WORD on idata and pulse par_err in the same cycle; loader reads SHALL return the raw word without a check.
REQ-031 Without the macro: storage SHALL be 32 bits wide and par_err SHALL be tied to 0.

Verification
REQ-032 Load 32'h12345678 to address 5 with ics low, then ics=1, iaddr=5 -> ld_ack one cycle after the request; idata=32'h12345678 one cycle after the fetch.
REQ-033 ics held high for 10 cycles while ld_req (write) is pending -> ld_ack stays 0 for those 10 cycles; write occurs in the first cycle with ics low; ld_ack is high the following cycle.
REQ-034 ics=1, iaddr=24'h001000 with ADDR_W=12 -> idata=32'hC0000000 next cycle; loader read of the same address -> ld_rdata=32'h0.
REQ-035 Write at cycle N, then fetch of the same address at cycle N+1 -> new data returned (no stale read).
REQ-036 rst_n pulsed low while in WAIT -> outputs at reset values; target word unchanged; no ld_ack.
REQ-037 TAWAS_IMEM_PARITY_EN defined, stored parity bit flipped by backdoor, then fetched -> idata=32'hC0000000 with a one-cycle par_err pulse.
